// File: rtl/nv_nvdla_sdp_y_cvt_pkg.sv
// Shared widths and arithmetic helpers for the SDP Y-path converter.
package nv_nvdla_sdp_y_cvt_pkg;

  localparam int CVT_DIFF_W = 33;  // exact in - offset
  localparam int CVT_PROD_W = 49;  // exact diff * scale
  localparam int CVT_RND_W  = 50;  // shifted product plus rounding carry

  // Arithmetic right shift by t with round-half-toward-+inf.
  // Shift amounts past the product width fall out naturally from the
  // 64-bit sign-extended view (sign fill, round bit taken from sign).
  function automatic logic signed [CVT_RND_W-1:0] rnd_shift(
    input logic signed [CVT_PROD_W-1:0] prod,
    input logic        [5:0]            t
  );
    logic signed [63:0]           p64;
    logic signed [63:0]           shifted;
    logic        [63:0]           below;
    logic signed [CVT_RND_W-1:0]  r;
    p64 = {{(64-CVT_PROD_W){prod[CVT_PROD_W-1]}}, prod};
    if (t == 6'd0) begin
      r = {prod[CVT_PROD_W-1], prod};
    end else begin
      shifted = p64 >>> t;
      below   = p64 >> (t - 6'd1);
      r = shifted[CVT_RND_W-1:0] + {{(CVT_RND_W-1){1'b0}}, below[0]};
    end
    return r;
  endfunction

  // Clamp a rounded value to a signed out_w-bit range; sat reports clamping.
  // The result is returned in 32 bits; callers keep the low out_w bits.
  function automatic logic [31:0] sat_to_w(
    input  logic signed [CVT_RND_W-1:0] r,
    input  int                          out_w,
    output logic                        sat
  );
    logic signed [63:0] rr;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic        [31:0] res;
    rr    = {{(64-CVT_RND_W){r[CVT_RND_W-1]}}, r};
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    sat   = 1'b1;
    if (rr > max_v) begin
      res = max_v[31:0];
    end else if (rr < min_v) begin
      res = min_v[31:0];
    end else begin
      res = rr[31:0];
      sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_y_cvt_lane.sv
// One lane of the converter: S1 offset-subtract, S2 scale-multiply,
// S3 round-shift and saturate. Pure datapath; the top supplies the enables.
module nv_nvdla_sdp_y_cvt_lane
  import nv_nvdla_sdp_y_cvt_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              s1_en,
  input  logic              s2_en,
  input  logic              s3_en,
  input  logic [IN_W-1:0]   lane_in,
  input  logic [31:0]       offset,
  input  logic              bypass_s0,
  input  logic              bypass_s1,
  input  logic [15:0]       scale_s1,
  input  logic              bypass_s2,
  input  logic [5:0]        trunc_s2,
  output logic [OUT_W-1:0]  lane_out,
  output logic              lane_sat
);

  logic signed [CVT_DIFF_W-1:0] diff_reg, diff_next;
  logic signed [CVT_PROD_W-1:0] prod_reg, prod_next;
  logic signed [CVT_RND_W-1:0]  rnd;
  logic        [31:0]           sat_val;
  logic                         sat_flag;
  logic        [OUT_W-1:0]      out_reg, out_next;
  logic                         sat_reg, sat_next;

  // S1: in - offset; in bypass the input is simply sign-extended
  always_comb begin
    diff_next = {{(CVT_DIFF_W-IN_W){lane_in[IN_W-1]}}, lane_in};
    if (!bypass_s0) diff_next = diff_next - {offset[31], offset};
  end

  // S2: exact signed product; bypass carries the extended input forward
  always_comb begin
    if (bypass_s1)
      prod_next = {{(CVT_PROD_W-CVT_DIFF_W){diff_reg[CVT_DIFF_W-1]}}, diff_reg};
    else
      prod_next = CVT_PROD_W'(diff_reg) * CVT_PROD_W'($signed(scale_s1));
  end

  // S3: round-shift then clamp to OUT_W; bypass never flags saturation
  always_comb begin
    rnd      = rnd_shift(prod_reg, trunc_s2);
    sat_flag = 1'b0;
    sat_val  = sat_to_w(rnd, OUT_W, sat_flag);
    if (bypass_s2) begin
      out_next = prod_reg[OUT_W-1:0];
      sat_next = 1'b0;
    end else begin
      out_next = sat_val[OUT_W-1:0];
      sat_next = sat_flag;
    end
  end

  // Stage registers load only when their stage advances
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      diff_reg <= '0;
      prod_reg <= '0;
      out_reg  <= '0;
      sat_reg  <= 1'b0;
    end else begin
      if (s1_en) diff_reg <= diff_next;
      if (s2_en) prod_reg <= prod_next;
      if (s3_en) begin
        out_reg <= out_next;
        sat_reg <= sat_next;
      end
    end
  end

  assign lane_out = out_reg;
  assign lane_sat = sat_reg;

endmodule

// File: rtl/nv_nvdla_sdp_y_cvt_array.sv
// Multi-lane Y-path converter: 3-stage valid/ready pipeline with collapsing
// bubbles, per-beat cfg capture and a saturating saturation-event counter.
module nv_nvdla_sdp_y_cvt_array
  import nv_nvdla_sdp_y_cvt_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   cfg_cvt_bypass,
  input  logic [31:0]            cfg_cvt_offset,
  input  logic [15:0]            cfg_cvt_scale,
  input  logic [5:0]             cfg_cvt_truncate,
  input  logic                   cfg_sat_cnt_clr,
  input  logic                   cvt_in_pvld,
  output logic                   cvt_in_prdy,
  input  logic [LANES*IN_W-1:0]  cvt_data_in,
  output logic                   cvt_out_pvld,
  input  logic                   cvt_out_prdy,
  output logic [LANES*OUT_W-1:0] cvt_data_out,
  output logic [LANES-1:0]       cvt_sat_out,
  output logic [31:0]            sat_cnt
);

  localparam int POP_W = $clog2(LANES + 1);

  logic              vld1_reg, vld2_reg, vld3_reg;
  logic              rdy1, rdy2, rdy3;
  logic              en1, en2, en3;
  logic              bypass_s1_reg, bypass_s2_reg;
  logic [15:0]       scale_s1_reg;
  logic [5:0]        trunc_s1_reg, trunc_s2_reg;
  logic [POP_W-1:0]  sat_pop;
  logic [32:0]       sat_sum;
  logic [31:0]       sat_cnt_reg, sat_cnt_next;

  // A stage can take new data when empty or when its successor can take its data
  assign rdy3 = !vld3_reg || cvt_out_prdy;
  assign rdy2 = !vld2_reg || rdy3;
  assign rdy1 = !vld1_reg || rdy2;
  assign en1  = rdy1 && cvt_in_pvld;
  assign en2  = rdy2 && vld1_reg;
  assign en3  = rdy3 && vld2_reg;

  assign cvt_in_prdy  = rdy1;
  assign cvt_out_pvld = vld3_reg;

  // Valid bits advance with their stage and hold while stalled
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld1_reg <= 1'b0;
      vld2_reg <= 1'b0;
      vld3_reg <= 1'b0;
    end else begin
      if (rdy1) vld1_reg <= cvt_in_pvld;
      if (rdy2) vld2_reg <= vld1_reg;
      if (rdy3) vld3_reg <= vld2_reg;
    end
  end

  // cfg travels down the pipe with its beat so later changes never touch it
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      bypass_s1_reg <= 1'b0;
      scale_s1_reg  <= '0;
      trunc_s1_reg  <= '0;
      bypass_s2_reg <= 1'b0;
      trunc_s2_reg  <= '0;
    end else begin
      if (en1) begin
        bypass_s1_reg <= cfg_cvt_bypass;
        scale_s1_reg  <= cfg_cvt_scale;
        trunc_s1_reg  <= cfg_cvt_truncate;
      end
      if (en2) begin
        bypass_s2_reg <= bypass_s1_reg;
        trunc_s2_reg  <= trunc_s1_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      nv_nvdla_sdp_y_cvt_lane #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_lane (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .s1_en           (en1),
        .s2_en           (en2),
        .s3_en           (en3),
        .lane_in         (cvt_data_in[gi*IN_W +: IN_W]),
        .offset          (cfg_cvt_offset),
        .bypass_s0       (cfg_cvt_bypass),
        .bypass_s1       (bypass_s1_reg),
        .scale_s1        (scale_s1_reg),
        .bypass_s2       (bypass_s2_reg),
        .trunc_s2        (trunc_s2_reg),
        .lane_out        (cvt_data_out[gi*OUT_W +: OUT_W]),
        .lane_sat        (cvt_sat_out[gi])
      );
    end
  endgenerate

  // Count saturated lanes on each accepted output beat; clear has priority
  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < LANES; i++) sat_pop = sat_pop + POP_W'(cvt_sat_out[i]);
    sat_sum      = {1'b0, sat_cnt_reg} + 33'(sat_pop);
    sat_cnt_next = sat_cnt_reg;
    if (cfg_sat_cnt_clr)
      sat_cnt_next = '0;
    else if (vld3_reg && cvt_out_prdy)
      sat_cnt_next = sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
  end

  // Counter register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) sat_cnt_reg <= '0;
    else                  sat_cnt_reg <= sat_cnt_next;
  end

  assign sat_cnt = sat_cnt_reg;

endmodule
